// File: rtl/rah_sched_pkg.sv
// Shared constants, header layout and FSM state type for the line scheduler.
// Imported by rah_rr_arbiter and rah_line_scheduler.
package rah_sched_pkg;

    localparam logic [3:0] HDR_MAGIC = 4'hA;
    localparam logic [3:0] NULL_ID   = 4'hF;

    localparam int unsigned HDR_MAGIC_LSB = 28;
    localparam int unsigned HDR_ID_LSB    = 24;
    localparam int unsigned HDR_SEQ_LSB   = 16;
    localparam int unsigned HDR_LEN_LSB   = 0;

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StPayload,
        StPad
    } sched_state_e;

    function automatic logic [31:0] build_header(input logic [3:0]  id,
                                                 input logic [7:0]  seq,
                                                 input logic [15:0] len);
        logic [31:0] hdr;
        hdr                        = '0;
        hdr[HDR_MAGIC_LSB +: 4]    = HDR_MAGIC;
        hdr[HDR_ID_LSB +: 4]       = id;
        hdr[HDR_SEQ_LSB +: 8]      = seq;
        hdr[HDR_LEN_LSB +: 16]     = len;
        return hdr;
    endfunction

endpackage

// File: rtl/rah_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly above the pointer,
// wrapping to the lowest index. The pointer register lives in the parent.
module rah_rr_arbiter
    import rah_sched_pkg::*;
#(
    parameter int unsigned TOTAL_APPS = 4
) (
    input  logic [TOTAL_APPS-1:0] req,
    input  logic [3:0]            pointer,
    output logic [TOTAL_APPS-1:0] grant,
    output logic [3:0]            index,
    output logic                  any
);

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        // Upper pass covers pointer+1..TOTAL_APPS-1, lower pass the wrapped range.
        for (int i = 0; i < int'(TOTAL_APPS); i++) begin
            if (!any && req[i] && (i > int'(pointer))) begin
                any      = 1'b1;
                index    = 4'(i);
                grant[i] = 1'b1;
            end
        end
        for (int i = 0; i < int'(TOTAL_APPS); i++) begin
            if (!any && req[i] && (i <= int'(pointer))) begin
                any      = 1'b1;
                index    = 4'(i);
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rah_line_scheduler.sv
// Round-robin line scheduler: one header, granted app payload, zero pad per line.
// Optional per-app grant statistics are built when RAH_SCHED_STATS_EN is defined.
module rah_line_scheduler
    import rah_sched_pkg::*;
#(
    parameter int unsigned TOTAL_APPS = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LINE_WORDS = 480,
    parameter int unsigned LVL_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             line_start,
    input  logic [TOTAL_APPS-1:0]            app_req,
    input  logic [TOTAL_APPS*LVL_W-1:0]      app_level,
    input  logic [TOTAL_APPS*DATA_WIDTH-1:0] app_rd_data,
    output logic [TOTAL_APPS-1:0]            app_rd_en,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [3:0]                       grant_id,
    output logic                             busy,
    output logic                             line_overrun,
    output logic [TOTAL_APPS*16-1:0]         stat_grant_cnt
);

    localparam logic [15:0] LAST_WORD = 16'(LINE_WORDS - 1);

    sched_state_e          state;
    logic [3:0]            pointer;
    logic [7:0]            line_seq;
    logic [15:0]           len;
    logic [15:0]           wcnt;
    logic [15:0]           wnext;

    logic [TOTAL_APPS-1:0] arb_grant;
    logic [3:0]            arb_index;
    logic                  arb_any;
    logic [LVL_W-1:0]      level_sel;
    logic [15:0]           len_pick;
    logic [DATA_WIDTH-1:0] data_sel;

    rah_rr_arbiter #(
        .TOTAL_APPS(TOTAL_APPS)
    ) u_arb (
        .req    (app_req),
        .pointer(pointer),
        .grant  (arb_grant),
        .index  (arb_index),
        .any    (arb_any)
    );

    always_comb begin
        level_sel = '0;
        for (int i = 0; i < int'(TOTAL_APPS); i++) begin
            if (arb_index == 4'(i)) level_sel = app_level[i*LVL_W +: LVL_W];
        end
    end

    always_comb begin
        if (!arb_any) begin
            len_pick = '0;
        end else if (32'(level_sel) > LINE_WORDS - 1) begin
            len_pick = LAST_WORD;
        end else begin
            len_pick = 16'(level_sel);
        end
    end

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < int'(TOTAL_APPS); i++) begin
            if (grant_id == 4'(i)) data_sel = app_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign wnext = wcnt + 16'd1;

    // wcnt is the index of the word currently on out_data (0 = header).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            pointer      <= 4'(TOTAL_APPS - 1);
            line_seq     <= '0;
            len          <= '0;
            wcnt         <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            app_rd_en    <= '0;
            line_overrun <= 1'b0;
        end else begin
            if (line_start && (state != StIdle)) line_overrun <= 1'b1;
            unique case (state)
                StIdle: begin
                    if (line_start) begin
                        state     <= StHeader;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= DATA_WIDTH'(build_header(arb_any ? arb_index : NULL_ID,
                                                              line_seq, len_pick));
                        line_seq  <= line_seq + 8'd1;
                        len       <= len_pick;
                        wcnt      <= '0;
                        app_rd_en <= (arb_any && (len_pick != 16'd0)) ? arb_grant : '0;
                        if (arb_any) begin
                            grant_id <= arb_index;
                            pointer  <= arb_index;
                        end
                    end
                end
                default: begin
                    if (wcnt == LAST_WORD) begin
                        state     <= StIdle;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        app_rd_en <= '0;
                    end else begin
                        wcnt <= wnext;
                        if (wnext <= len) begin
                            state    <= StPayload;
                            out_data <= data_sel;
                        end else begin
                            state    <= StPad;
                            out_data <= '0;
                        end
                        // Pops run for len cycles starting with the header cycle.
                        if (wnext >= len) app_rd_en <= '0;
                    end
                end
            endcase
        end
    end

`ifdef RAH_SCHED_STATS_EN
    logic [TOTAL_APPS*16-1:0] stat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt <= '0;
        end else if ((state == StIdle) && line_start && arb_any) begin
            for (int i = 0; i < int'(TOTAL_APPS); i++) begin
                if (arb_grant[i] && (stat_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    stat_cnt[i*16 +: 16] <= stat_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign stat_grant_cnt = stat_cnt;
`else
    assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_rah_line_scheduler.sv
// Self-checking bench for rah_line_scheduler with LINE_WORDS=8 and four show-ahead FIFO models.
module tb_rah_line_scheduler;

    localparam int unsigned APPS = 4;
    localparam int unsigned DW   = 64;
    localparam int unsigned LW   = 8;
    localparam int unsigned LVW  = 16;
`ifdef RAH_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 line_start = 1'b0;
    logic [APPS-1:0]      app_req = '0;
    logic [APPS*LVW-1:0]  app_level = '0;
    logic [APPS*DW-1:0]   app_rd_data = '0;
    logic [APPS-1:0]      app_rd_en;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [3:0]           grant_id;
    logic                 busy;
    logic                 line_overrun;
    logic [APPS*16-1:0]   stat_grant_cnt;

    always #5 clk = ~clk;

    rah_line_scheduler #(
        .TOTAL_APPS(APPS),
        .DATA_WIDTH(DW),
        .LINE_WORDS(LW),
        .LVL_W     (LVW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .line_start    (line_start),
        .app_req       (app_req),
        .app_level     (app_level),
        .app_rd_data   (app_rd_data),
        .app_rd_en     (app_rd_en),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .grant_id      (grant_id),
        .busy          (busy),
        .line_overrun  (line_overrun),
        .stat_grant_cnt(stat_grant_cnt)
    );

    typedef struct {
        int         due;
        logic [63:0] data;
        logic [3:0]  rden;
        logic [3:0]  gid;
    } exp_t;

    typedef struct {
        logic [3:0]      req;
        logic [3:0][7:0] lvl;
        logic [3:0]      gid;
        int              len;
        logic [3:0]      held;
    } vec_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          nvec = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          total_pops = 0;
    logic [7:0]  seq_exp = '0;
    logic [63:0] fmem[APPS][16];
    int          fcnt[APPS];
    logic [3:0]  pend = '0;
    vec_t        vt[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, req);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [3:0] id, input logic [7:0] s,
                                        input logic [15:0] l);
        return {32'h0, 4'hA, id, s, l};
    endfunction

    function automatic vec_t mk(input logic [3:0] req, input logic [7:0] l3, input logic [7:0] l2,
                                input logic [7:0] l1, input logic [7:0] l0, input logic [3:0] gid,
                                input int len, input logic [3:0] held);
        vec_t v;
        v.req  = req;
        v.lvl  = {l3, l2, l1, l0};
        v.gid  = gid;
        v.len  = len;
        v.held = held;
        return v;
    endfunction

    task automatic refresh();
        for (int i = 0; i < int'(APPS); i++) begin
            app_level[i*LVW +: LVW] = 16'(fcnt[i]);
            app_rd_data[i*DW +: DW] = (fcnt[i] > 0) ? fmem[i][0] : 64'h0;
        end
    endtask

    task automatic load(input logic [3:0][7:0] lv);
        for (int i = 0; i < int'(APPS); i++) begin
            fcnt[i] = int'(lv[i]);
            for (int j = 0; j < 16; j++) fmem[i][j] = {$urandom, $urandom};
        end
        refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Pushes the full expected line (header, FIFO words, pad) and pulses line_start.
    task automatic start_line(input logic [3:0] hid, input int len, input logic [3:0] held);
        exp_t e;
        line_start = 1'b1;
        for (int k = 0; k < int'(LW); k++) begin
            e.due  = cyc + 1 + k;
            e.gid  = held;
            e.rden = (k < len) ? (4'b0001 << hid) : 4'b0000;
            if (k == 0)        e.data = hdr(hid, seq_exp, 16'(len));
            else if (k <= len) e.data = fmem[int'(hid)][k-1];
            else               e.data = 64'h0;
            expq.push_back(e);
        end
        seq_exp = seq_exp + 8'd1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (expq.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        nvec++;
        if (expq.size() > 0) begin
            nfail++;
            $display("FAIL wait_idle: %0d words still outstanding, expected 0", expq.size());
            expq.delete();
        end
        tick();
    endtask

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) pend = app_rd_en;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < int'(APPS); i++) begin
            if (pend[i]) begin
                total_pops++;
                if (fcnt[i] > 0) begin
                    for (int j = 0; j < 15; j++) fmem[i][j] = fmem[i][j+1];
                    fcnt[i]--;
                end
            end
        end
        pend = '0;
        refresh();
    end

    always @(negedge clk) begin
        if (expq.size() > 0 && expq[0].due == cyc) begin
            mon_e = expq.pop_front();
            chk("line_valid", {63'h0, out_valid}, 64'h1);
            chk("line_busy", {63'h0, busy}, 64'h1);
            chk("line_data", out_data, mon_e.data);
            chk("line_rden", {60'h0, app_rd_en}, {60'h0, mon_e.rden});
            chk("line_gid", {60'h0, grant_id}, {60'h0, mon_e.gid});
        end else begin
            chk("idle_valid", {63'h0, out_valid}, 64'h0);
            chk("idle_busy", {63'h0, busy}, 64'h0);
            chk("idle_rden", {60'h0, app_rd_en}, 64'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int pops0;
        vt[0]  = mk(4'b1101, 8'd10, 8'd10, 8'd0, 8'd10, 4'd0, 7, 4'd0);
        vt[1]  = mk(4'b1101, 8'd10, 8'd10, 8'd0, 8'd10, 4'd2, 7, 4'd2);
        vt[2]  = mk(4'b1101, 8'd10, 8'd10, 8'd0, 8'd10, 4'd3, 7, 4'd3);
        vt[3]  = mk(4'b1101, 8'd10, 8'd10, 8'd0, 8'd10, 4'd0, 7, 4'd0);
        vt[4]  = mk(4'b0010, 8'd0, 8'd0, 8'd3, 8'd0, 4'd1, 3, 4'd1);
        vt[5]  = mk(4'b0000, 8'd0, 8'd0, 8'd0, 8'd5, 4'hF, 0, 4'd1);
        vt[6]  = mk(4'b0001, 8'd0, 8'd0, 8'd0, 8'd0, 4'd0, 0, 4'd0);
        vt[7]  = mk(4'b1000, 8'd7, 8'd0, 8'd0, 8'd0, 4'd3, 7, 4'd3);
        vt[8]  = mk(4'b0100, 8'd0, 8'd2, 8'd0, 8'd0, 4'd2, 2, 4'd2);
        vt[9]  = mk(4'b1111, 8'd1, 8'd1, 8'd1, 8'd1, 4'd3, 1, 4'd3);
        vt[10] = mk(4'b1011, 8'd9, 8'd0, 8'd9, 8'd5, 4'd0, 5, 4'd0);

        load({8'd0, 8'd0, 8'd0, 8'd0});
        #1;
        chk("reset_valid", {63'h0, out_valid}, 64'h0);
        chk("reset_busy", {63'h0, busy}, 64'h0);
        chk("reset_data", out_data, 64'h0);
        chk("reset_gid", {60'h0, grant_id}, 64'h0);
        chk("reset_overrun", {63'h0, line_overrun}, 64'h0);
        chk("reset_rden", {60'h0, app_rd_en}, 64'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 11; v++) begin
            load(vt[v].lvl);
            app_req = vt[v].req;
            tick();
            pops0 = total_pops;
            start_line(vt[v].gid, vt[v].len, vt[v].held);
            wait_idle();
            chk("grant_hold", {60'h0, grant_id}, {60'h0, vt[v].held});
            chk("pop_count", 64'(total_pops - pops0), 64'(vt[v].len));
        end
        chk("overrun_clear", {63'h0, line_overrun}, 64'h0);

        // Pulses 3 cycles in and on the last busy cycle must both be ignored.
        load({8'd0, 8'd0, 8'd3, 8'd0});
        app_req = 4'b0010;
        tick();
        start_line(4'd1, 3, 4'd1);
        repeat (2) tick();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (4) tick();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        wait_idle();
        chk("overrun_set", {63'h0, line_overrun}, 64'h1);
        load({8'd0, 8'd0, 8'd3, 8'd0});
        tick();
        start_line(4'd1, 3, 4'd1);
        wait_idle();
        chk("overrun_sticky", {63'h0, line_overrun}, 64'h1);

        // Reset dropped while payload word 2 is on the output.
        load({8'd10, 8'd10, 8'd10, 8'd10});
        app_req = 4'b1111;
        tick();
        start_line(4'd2, 7, 4'd2);
        repeat (3) tick();
        rst_n = 1'b0;
        expq.delete();
        seq_exp = '0;
        #1;
        chk("midrst_valid", {63'h0, out_valid}, 64'h0);
        chk("midrst_rden", {60'h0, app_rd_en}, 64'h0);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_overrun", {63'h0, line_overrun}, 64'h0);
        chk("postrst_gid", {60'h0, grant_id}, 64'h0);
        load({8'd10, 8'd10, 8'd10, 8'd10});
        tick();
        start_line(4'd0, 7, 4'd0);
        wait_idle();

        // Statistics: three grants to app 2 and one null line from a clean reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seq_exp = '0;
        tick();
        for (int n = 0; n < 3; n++) begin
            load({8'd0, 8'd1, 8'd0, 8'd0});
            app_req = 4'b0100;
            tick();
            start_line(4'd2, 1, 4'd2);
            wait_idle();
        end
        app_req = 4'b0000;
        start_line(4'hF, 0, 4'd2);
        wait_idle();
        for (int i = 0; i < int'(APPS); i++) begin
            chk($sformatf("stat_cnt%0d", i), {48'h0, stat_grant_cnt[i*16 +: 16]},
                (STATS && i == 2) ? 64'd3 : 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
